// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register. Owns the PC and keeps at most
// one request outstanding to an in-order, variable-latency instruction memory.
module fetch_stage #(
   parameter int ADDR_W  = 32,
   parameter int INSTR_W = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               freeze,
   input  logic               branch_taken,
   input  logic [ADDR_W-1:0]  branch_addr,
   output logic               imem_req,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic               imem_ready,
   input  logic               imem_rvalid,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic               if_id_valid,
   output logic [ADDR_W-1:0]  if_id_pc,
   output logic [INSTR_W-1:0] if_id_instr
);

   typedef enum logic [1:0] {ISSUE, WAIT, HOLD, DISCARD} state_t;

   state_t               state_q, state_d;
   logic [ADDR_W-1:0]    pc_q, pc_d;
   logic [ADDR_W-1:0]    fetch_pc_q, fetch_pc_d;
   logic [INSTR_W-1:0]   hold_instr_q, hold_instr_d;
   logic [ADDR_W-1:0]    hold_pc_q, hold_pc_d;
   logic                 if_id_valid_q, if_id_valid_d;
   logic [ADDR_W-1:0]    if_id_pc_q, if_id_pc_d;
   logic [INSTR_W-1:0]   if_id_instr_q, if_id_instr_d;

   logic                 deliver;
   logic [INSTR_W-1:0]   deliver_instr;
   logic [ADDR_W-1:0]    deliver_pc;

   assign imem_req    = (state_q == ISSUE) && !branch_taken && rst;
   assign imem_addr   = pc_q;
   assign if_id_valid = if_id_valid_q;
   assign if_id_pc    = if_id_pc_q;
   assign if_id_instr = if_id_instr_q;

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      fetch_pc_d    = fetch_pc_q;
      hold_instr_d  = hold_instr_q;
      hold_pc_d     = hold_pc_q;
      deliver       = 1'b0;
      deliver_instr = imem_rdata;
      deliver_pc    = fetch_pc_q + ADDR_W'(4);

      case (state_q)
         ISSUE: begin
            if (branch_taken) begin
               pc_d = branch_addr;
            end else if (imem_req && imem_ready) begin
               fetch_pc_d = pc_q;
               state_d    = WAIT;
            end
         end
         WAIT: begin
            if (branch_taken) begin
               pc_d    = branch_addr;
               state_d = imem_rvalid ? ISSUE : DISCARD;
            end else if (imem_rvalid) begin
               pc_d = pc_q + ADDR_W'(4);
               if (freeze) begin
                  hold_instr_d = imem_rdata;
                  hold_pc_d    = fetch_pc_q + ADDR_W'(4);
                  state_d      = HOLD;
               end else begin
                  deliver = 1'b1;
                  state_d = ISSUE;
               end
            end
         end
         HOLD: begin
            if (branch_taken) begin
               pc_d         = branch_addr;
               hold_instr_d = '0;
               hold_pc_d    = '0;
               state_d      = ISSUE;
            end else if (!freeze) begin
               deliver       = 1'b1;
               deliver_instr = hold_instr_q;
               deliver_pc    = hold_pc_q;
               state_d       = ISSUE;
            end
         end
         DISCARD: begin
            if (branch_taken) begin
               pc_d = branch_addr;
            end
            if (imem_rvalid) begin
               state_d = ISSUE;
            end
         end
         default: state_d = ISSUE;
      endcase
   end

   // A flush beats a stall, and a stall beats a delivery; otherwise insert a bubble.
   always_comb begin
      if_id_valid_d = if_id_valid_q;
      if_id_pc_d    = if_id_pc_q;
      if_id_instr_d = if_id_instr_q;
      if (branch_taken) begin
         if_id_valid_d = 1'b0;
         if_id_pc_d    = '0;
         if_id_instr_d = '0;
      end else if (freeze) begin
         if_id_valid_d = if_id_valid_q;
      end else if (deliver) begin
         if_id_valid_d = 1'b1;
         if_id_pc_d    = deliver_pc;
         if_id_instr_d = deliver_instr;
      end else begin
         if_id_valid_d = 1'b0;
         if_id_instr_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= ISSUE;
         pc_q          <= '0;
         fetch_pc_q    <= '0;
         hold_instr_q  <= '0;
         hold_pc_q     <= '0;
         if_id_valid_q <= 1'b0;
         if_id_pc_q    <= '0;
         if_id_instr_q <= '0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         fetch_pc_q    <= fetch_pc_d;
         hold_instr_q  <= hold_instr_d;
         hold_pc_q     <= hold_pc_d;
         if_id_valid_q <= if_id_valid_d;
         if_id_pc_q    <= if_id_pc_d;
         if_id_instr_q <= if_id_instr_d;
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vector table, hand-written reset
// sequence, then randomized traffic against a transaction-level reference model.
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        freeze;
   logic        branch_taken;
   logic [31:0] branch_addr;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        if_id_valid;
   logic [31:0] if_id_pc;
   logic [31:0] if_id_instr;

   int testsRun = 0;
   int testsFailed = 0;

   fetch_stage #(.ADDR_W(32), .INSTR_W(32)) dut (
      .clk(clk), .rst(rst), .freeze(freeze), .branch_taken(branch_taken),
      .branch_addr(branch_addr), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .if_id_valid(if_id_valid), .if_id_pc(if_id_pc), .if_id_instr(if_id_instr)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        fr;
      logic        bt;
      logic [31:0] ba;
      logic        rdy;
      logic        rv;
      logic [31:0] rd;
      logic        expReq;
      logic [31:0] expAddr;
      logic        expValid;
      logic [31:0] expPc;
      logic [31:0] expInstr;
   } vec_t;

   vec_t vecs[22];

   function automatic vec_t mk(logic fr, logic bt, logic [31:0] ba, logic rdy, logic rv,
                               logic [31:0] rd, logic eReq, logic [31:0] eAddr,
                               logic eValid, logic [31:0] ePc, logic [31:0] eInstr);
      vec_t v;
      v.fr = fr; v.bt = bt; v.ba = ba; v.rdy = rdy; v.rv = rv; v.rd = rd;
      v.expReq = eReq; v.expAddr = eAddr; v.expValid = eValid;
      v.expPc = ePc; v.expInstr = eInstr;
      return v;
   endfunction

   task automatic applyStimulus(input logic fr, input logic bt, input logic [31:0] ba,
                                input logic rdy, input logic rv, input logic [31:0] rd);
      @(negedge clk);
      freeze       = fr;
      branch_taken = bt;
      branch_addr  = ba;
      imem_ready   = rdy;
      imem_rvalid  = rv;
      imem_rdata   = rd;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      testsRun++;
      if (act !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: tracks the fetch in terms of transactions rather than states.
   logic [31:0] mPc, mFpc, mIfPc, mIfInstr;
   logic        mValid, mInflight, mDropNext;
   typedef struct { logic [31:0] instr; logic [31:0] pc; } held_t;
   held_t held[$];

   function automatic logic mIssuing();
      return !mInflight && !mDropNext && (held.size() == 0);
   endfunction

   task automatic modelReset();
      mPc = 0; mFpc = 0; mIfPc = 0; mIfInstr = 0; mValid = 0;
      mInflight = 0; mDropNext = 0; held.delete();
   endtask

   task automatic modelStep(input logic fr, input logic bt, input logic [31:0] ba,
                            input logic rdy, input logic rv, input logic [31:0] rd);
      logic        haveNew = 0;
      held_t       newItem;
      held_t       h;
      if (bt) begin
         mPc = ba;
         held.delete();
         if (mInflight) begin
            mInflight = 0;
            mDropNext = !rv;
         end else if (mDropNext && rv) begin
            mDropNext = 0;
         end
         mValid = 0; mIfPc = 0; mIfInstr = 0;
      end else begin
         if (mInflight) begin
            if (rv) begin
               mInflight = 0;
               newItem.instr = rd;
               newItem.pc = mFpc + 32'd4;
               mPc = mPc + 32'd4;
               if (fr) held.push_back(newItem);
               else haveNew = 1;
            end
         end else if (held.size() > 0) begin
            if (!fr) begin
               newItem = held.pop_front();
               haveNew = 1;
            end
         end else if (mDropNext) begin
            if (rv) mDropNext = 0;
         end else if (rdy) begin
            mInflight = 1;
            mFpc = mPc;
         end
         if (!fr) begin
            if (haveNew) begin
               mValid = 1; mIfPc = newItem.pc; mIfInstr = newItem.instr;
            end else begin
               mValid = 0; mIfInstr = 0;
            end
         end
      end
      h = newItem;
   endtask

   logic        memPending;
   int          memDelay;

   initial begin
      rst = 1'b0; freeze = 0; branch_taken = 0; branch_addr = 0;
      imem_ready = 0; imem_rvalid = 0; imem_rdata = 0;

      // Cycle-by-cycle vectors: inputs, then expected req/addr before the edge and IF/ID after it.
      vecs[0]  = mk(0,0,0,            1,0,0,            1,32'h0,       0,32'h0,       32'h0);
      vecs[1]  = mk(0,0,0,            1,1,32'hE3A01005, 0,32'h0,       1,32'h4,       32'hE3A01005);
      vecs[2]  = mk(0,0,0,            1,0,0,            1,32'h4,       0,32'h4,       32'h0);
      vecs[3]  = mk(0,0,0,            1,1,32'hE2811001, 0,32'h4,       1,32'h8,       32'hE2811001);
      vecs[4]  = mk(1,0,0,            1,0,0,            1,32'h8,       1,32'h8,       32'hE2811001);
      vecs[5]  = mk(1,0,0,            1,1,32'hAAAA0001, 0,32'h8,       1,32'h8,       32'hE2811001);
      vecs[6]  = mk(1,0,0,            1,0,0,            0,32'hC,       1,32'h8,       32'hE2811001);
      vecs[7]  = mk(1,0,0,            1,0,0,            0,32'hC,       1,32'h8,       32'hE2811001);
      vecs[8]  = mk(0,0,0,            1,0,0,            0,32'hC,       1,32'hC,       32'hAAAA0001);
      vecs[9]  = mk(0,0,0,            1,0,0,            1,32'hC,       0,32'hC,       32'h0);
      vecs[10] = mk(0,1,32'h100,      1,0,0,            0,32'hC,       0,32'h0,       32'h0);
      vecs[11] = mk(0,0,0,            1,0,0,            0,32'h100,     0,32'h0,       32'h0);
      vecs[12] = mk(0,0,0,            1,1,32'hDEADBEEF, 0,32'h100,     0,32'h0,       32'h0);
      vecs[13] = mk(0,0,0,            0,0,0,            1,32'h100,     0,32'h0,       32'h0);
      vecs[14] = mk(0,0,0,            0,0,0,            1,32'h100,     0,32'h0,       32'h0);
      vecs[15] = mk(0,0,0,            0,0,0,            1,32'h100,     0,32'h0,       32'h0);
      vecs[16] = mk(0,0,0,            0,0,0,            1,32'h100,     0,32'h0,       32'h0);
      vecs[17] = mk(0,0,0,            1,0,0,            1,32'h100,     0,32'h0,       32'h0);
      vecs[18] = mk(1,1,32'hFFFFFFFC, 1,1,32'h5555AAAA, 0,32'h100,     0,32'h0,       32'h0);
      vecs[19] = mk(0,0,0,            1,0,0,            1,32'hFFFFFFFC,0,32'h0,       32'h0);
      vecs[20] = mk(0,0,0,            1,1,32'h12345678, 0,32'hFFFFFFFC,1,32'h0,       32'h12345678);
      vecs[21] = mk(0,0,0,            0,0,0,            1,32'h0,       0,32'h0,       32'h0);

      repeat (2) @(negedge clk);
      #1;
      checkOutput("reset_req", {31'b0, imem_req}, 32'h0);
      checkOutput("reset_addr", imem_addr, 32'h0);
      checkOutput("reset_valid", {31'b0, if_id_valid}, 32'h0);
      checkOutput("reset_pc", if_id_pc, 32'h0);
      checkOutput("reset_instr", if_id_instr, 32'h0);
      @(negedge clk);
      rst = 1'b1;

      for (int i = 0; i < 22; i++) begin
         applyStimulus(vecs[i].fr, vecs[i].bt, vecs[i].ba, vecs[i].rdy, vecs[i].rv, vecs[i].rd);
         #1;
         checkOutput($sformatf("vec%0d_req", i), {31'b0, imem_req}, {31'b0, vecs[i].expReq});
         checkOutput($sformatf("vec%0d_addr", i), imem_addr, vecs[i].expAddr);
         @(posedge clk);
         #1;
         checkOutput($sformatf("vec%0d_valid", i), {31'b0, if_id_valid}, {31'b0, vecs[i].expValid});
         checkOutput($sformatf("vec%0d_pc", i), if_id_pc, vecs[i].expPc);
         checkOutput($sformatf("vec%0d_instr", i), if_id_instr, vecs[i].expInstr);
      end

      // Reset while a request is outstanding, then a stray response after release.
      applyStimulus(0, 1, 32'h200, 0, 0, 0);
      applyStimulus(0, 0, 0, 1, 0, 0);
      applyStimulus(0, 0, 0, 1, 1, 32'h77778888);
      @(posedge clk);
      #1;
      checkOutput("pre_rst_valid", {31'b0, if_id_valid}, 32'h1);
      applyStimulus(0, 0, 0, 1, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0);
      rst = 1'b0;
      #1;
      checkOutput("midrst_req", {31'b0, imem_req}, 32'h0);
      checkOutput("midrst_addr", imem_addr, 32'h0);
      checkOutput("midrst_valid", {31'b0, if_id_valid}, 32'h0);
      checkOutput("midrst_pc", if_id_pc, 32'h0);
      checkOutput("midrst_instr", if_id_instr, 32'h0);
      @(negedge clk);
      rst = 1'b1;
      applyStimulus(0, 0, 0, 0, 1, 32'hBADBAD00);
      #1;
      checkOutput("stray_req", {31'b0, imem_req}, 32'h1);
      checkOutput("stray_addr", imem_addr, 32'h0);
      @(posedge clk);
      #1;
      checkOutput("stray_valid", {31'b0, if_id_valid}, 32'h0);
      checkOutput("stray_instr", if_id_instr, 32'h0);
      applyStimulus(0, 0, 0, 1, 0, 0);
      #1;
      checkOutput("post_rst_addr", imem_addr, 32'h0);
      applyStimulus(0, 0, 0, 0, 1, 32'h11110000);
      @(posedge clk);
      #1;
      checkOutput("post_rst_valid", {31'b0, if_id_valid}, 32'h1);
      checkOutput("post_rst_pc", if_id_pc, 32'h4);
      checkOutput("post_rst_instr", if_id_instr, 32'h11110000);

      // Randomized traffic against the reference model and a variable-latency memory.
      applyStimulus(0, 0, 0, 0, 0, 0);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      modelReset();
      memPending = 0;
      memDelay = 0;
      for (int i = 0; i < 3000; i++) begin
         logic        fr, bt, rdy, rv, expReq;
         logic [31:0] ba, rd;
         rv  = memPending && (memDelay == 0);
         rd  = $urandom;
         fr  = ($urandom_range(0, 2) == 0);
         bt  = ($urandom_range(0, 9) == 0);
         ba  = $urandom;
         rdy = 1'($urandom_range(0, 1));
         applyStimulus(fr, bt, ba, rdy, rv, rd);
         expReq = mIssuing() && !bt;
         #1;
         checkOutput("rand_req", {31'b0, imem_req}, {31'b0, expReq});
         checkOutput("rand_addr", imem_addr, mPc);
         @(posedge clk);
         if (rv) memPending = 0;
         if (expReq && rdy) begin
            memPending = 1;
            memDelay = $urandom_range(0, 2);
         end else if (memPending && memDelay > 0) begin
            memDelay--;
         end
         modelStep(fr, bt, ba, rdy, rv, rd);
         #1;
         checkOutput("rand_valid", {31'b0, if_id_valid}, {31'b0, mValid});
         checkOutput("rand_pc", if_id_pc, mIfPc);
         checkOutput("rand_instr", if_id_instr, mIfInstr);
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register of the 5-stage ARM core.
- Owns the PC and issues requests to an in-order, variable-latency instruction memory with at most one request outstanding.
- Drives the IF/ID register consumed by the ID stage.
- Stalls on the `freeze` signal from the hazard detection unit; flushes and redirects on taken branches from EXE.

Parameters:
- ADDR_W, 32, PC / instruction-memory address width.
- INSTR_W, 32, instruction word width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous active-low reset.
- freeze  in  1  hazard stall from the hazard unit; IF/ID must hold.
- branch_taken  in  1  taken-branch redirect from EXE; priority over freeze.
- branch_addr  in  ADDR_W  branch target; used as-is, no alignment masking.
- imem_req  out  1  request valid to instruction memory.
- imem_addr  out  ADDR_W  request address; equals the PC register.
- imem_ready  in  1  memory accepts the request this cycle when imem_req=1.
- imem_rvalid  in  1  response valid; in order, at most one outstanding.
- imem_rdata  in  INSTR_W  response instruction word.
- if_id_valid  out  1  IF/ID holds a real instruction.
- if_id_pc  out  ADDR_W  fetch address + 4 of the held instruction.
- if_id_instr  out  INSTR_W  held instruction.

Behaviour:
- Reset while rst=0, asynchronous:
  - pc=0, state=ISSUE.
  - if_id_valid=0, if_id_pc=0, if_id_instr=0, hold buffer cleared.
  - imem_req=0 while in reset.
- Reset asserted mid-operation aborts any pending request. A response arriving after reset release while in ISSUE is ignored.
- States: ISSUE, WAIT, HOLD, DISCARD.
- imem_req = (state==ISSUE) && !branch_taken && rst. This is combinational.
- imem_addr = pc.
- ISSUE:
  - branch_taken: pc<=branch_addr; stay in ISSUE; no request is issued.
  - Otherwise, imem_req && imem_ready: fetch_pc<=pc, go to WAIT.
  - Otherwise, stay in ISSUE.
  - imem_rvalid is ignored in this state.
- WAIT:
  - branch_taken: pc<=branch_addr.
    - imem_rvalid in the same cycle: drop the response, go to ISSUE.
    - No imem_rvalid: go to DISCARD.
  - imem_rvalid && !freeze: if_id_instr<=imem_rdata, if_id_pc<=fetch_pc+4, if_id_valid<=1, pc<=pc+4, go to ISSUE.
  - imem_rvalid && freeze: capture imem_rdata and fetch_pc+4 into the hold buffer, pc<=pc+4, go to HOLD.
- HOLD:
  - branch_taken: discard the buffer, pc<=branch_addr, go to ISSUE.
  - !freeze: load IF/ID from the buffer with valid=1, go to ISSUE.
  - freeze: stay in HOLD.
- DISCARD:
  - The next imem_rvalid is dropped and the state goes to ISSUE.
  - branch_taken here: pc<=branch_addr, stay in DISCARD (or go to ISSUE if rvalid arrives the same cycle).
- IF/ID register rules, highest priority first:
  1. branch_taken: if_id_valid<=0, if_id_instr<=0, if_id_pc<=0. A flush overrides freeze and any arriving response.
  2. freeze: IF/ID holds all fields unchanged.
  3. New instruction delivered (WAIT with rvalid, or HOLD release): load it.
  4. Otherwise: bubble, if_id_valid<=0, if_id_instr<=0, if_id_pc unchanged.
- Arithmetic: pc+4 and fetch_pc+4 wrap modulo 2^ADDR_W with no overflow flag.
- Throughput and latency:
  - Best case is 1 instruction per 2 cycles: ISSUE accepted, then rvalid on the next cycle in WAIT.
  - if_id_* is updated on the edge where rvalid is sampled.
- Freeze asserted in ISSUE or WAIT without rvalid has no effect on fetch progress. The memory request still proceeds.
- imem_addr must remain stable while imem_req=1 and imem_ready=0. pc changes only on branch_taken, which also drops imem_req.

Test Plan:
- Reset, then imem_ready=1 always and rvalid 1 cycle after acceptance returning 0xE3A01005, 0xE2811001 → imem_addr 0x0 then 0x4; if_id_pc=0x4 then 0x8; if_id_valid pulses 1 every other cycle.
- Response arrives while freeze=1 for 3 cycles → IF/ID keeps its previous contents; on freeze deassert the held instruction appears with if_id_pc=fetch_pc+4; no re-request of the same address.
- branch_taken=1, branch_addr=0x100 while in WAIT with rvalid 2 cycles later → the late response is dropped; IF/ID is flushed to valid=0; the next imem_addr is 0x100.
- branch_taken and imem_rvalid in the same cycle with freeze=1 → IF/ID is flushed (valid=0, instr=0), the response is dropped, state goes to ISSUE, and pc=branch_addr.
- imem_ready held low for 4 cycles → imem_req stays 1 and imem_addr is stable; pc=0xFFFFFFFC fetch → next imem_addr=0x0 and if_id_pc=0x0.
- rst pulled low while in WAIT, rvalid asserted 1 cycle after release → all outputs are 0 during reset; the stray response is ignored; the first request after release is to 0x0.
